// File: rtl/axi_pkg.sv
// Shared AXI3 slave types: burst encodings, response codes, channel FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI3 bus bundle between a bench master and the memory slave.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on AW, W, B, AR and R channels.
interface axi_inf #(
    parameter int ID_W = 4
);
    // write address
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awqos;
    logic            awregion;
    logic            awvalid;
    logic            awready;
    // write data
    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    // write response
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    // read address
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arqos;
    logic            arregion;
    logic            arvalid;
    logic            arready;
    // read data
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_addr_gen.sv
// Next-beat address and burst legality for one AXI channel.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: addr/len/size/burst describe the current beat; next_addr is the
// following beat's byte address, legal is low for reserved burst, size>4B
// or a WRAP length other than 2/4/8/16 beats.
module axi_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        legal
);

    logic [31:0] step;
    logic [31:0] span_mask;

    always_comb begin
        step      = 32'd1 << size;
        // WRAP window is (len+1) beats of 2^size bytes, aligned to its own size
        span_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;

        legal = 1'b1;
        if (burst == BURST_RSVD || size > 3'd2) begin
            legal = 1'b0;
        end
        if (burst == BURST_WRAP &&
            !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
            legal = 1'b0;
        end

        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~span_mask) | ((addr + step) & span_mask);
            default:     next_addr = addr + step;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI3 memory-backed slave: independent write and read FSMs over one word array.
// Latency: wready / rvalid(beat 0) one cycle after AW / AR accept; bvalid one cycle after last W.
// Backpressure: one beat per cycle when ready; B and R outputs hold stable until bready / rready.
// Ports: aclk, arst (async active-low), axi (slave modport of axi_inf).
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ID_W      = 4
) (
    input  logic  aclk,
    input  logic  arst,
    axi_inf.slave axi
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    // Storage is deliberately not reset: contents survive arst.
    logic [31:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return {2'b00, a[31:2]} < 32'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [31:0] a);
        return a[IDX_W+1:2];
    endfunction

    // Lock/cache/prot/qos/region carry no meaning for this target.
    logic unused_sideband;
    assign unused_sideband = ^{axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion,
                               axi.arlock, axi.arcache, axi.arprot, axi.arqos, axi.arregion};

    // ---------------------------------------------------------------- write
    wr_state_e       w_state_q, w_state_d;
    logic            awready_q, awready_d;
    logic            wready_q,  wready_d;
    logic            bvalid_q,  bvalid_d;
    logic [ID_W-1:0] bid_q,     bid_d;
    logic [1:0]      bresp_q,   bresp_d;
    logic [ID_W-1:0] w_id_q,    w_id_d;
    logic [31:0]     w_addr_q,  w_addr_d;
    logic [3:0]      w_len_q,   w_len_d;
    logic [2:0]      w_size_q,  w_size_d;
    logic [1:0]      w_burst_q, w_burst_d;
    logic [3:0]      w_beat_q,  w_beat_d;
    logic            w_err_q,   w_err_d;

    logic            w_beat_err;
    logic [31:0]     w_next_addr;
    logic            w_legal;
    logic            mem_we;

    axi_addr_gen u_wr_gen (
        .addr      (w_addr_q),
        .len       (w_len_q),
        .size      (w_size_q),
        .burst     (w_burst_q),
        .next_addr (w_next_addr),
        .legal     (w_legal)
    );

    always_comb begin
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        w_id_d     = w_id_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_size_d   = w_size_q;
        w_burst_d  = w_burst_q;
        w_beat_d   = w_beat_q;
        w_err_d    = w_err_q;
        w_beat_err = 1'b0;
        mem_we     = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi.awvalid && awready_q) begin
                    w_id_d    = axi.awid;
                    w_addr_d  = axi.awaddr;
                    w_len_d   = axi.awlen;
                    w_size_d  = axi.awsize;
                    w_burst_d = axi.awburst;
                    w_beat_d  = 4'd0;
                    w_err_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi.wvalid && wready_q) begin
                    // wlast never ends the burst early; it is only cross-checked
                    w_beat_err = !w_legal || !in_range(w_addr_q) || (axi.wid != w_id_q) ||
                                 (axi.wlast != (w_beat_q == w_len_q));
                    mem_we     = !w_beat_err;
                    w_err_d    = w_err_q | w_beat_err;
                    w_addr_d   = w_next_addr;
                    w_beat_d   = w_beat_q + 4'd1;
                    if (w_beat_q == w_len_q) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        bresp_d   = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi.bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) begin
                    mem[widx(w_addr_q)][8*b +: 8] <= axi.wdata[8*b +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read
    rd_state_e       r_state_q, r_state_d;
    logic            arready_q, arready_d;
    logic            rvalid_q,  rvalid_d;
    logic            rlast_q,   rlast_d;
    logic [ID_W-1:0] rid_q,     rid_d;
    logic [31:0]     rdata_q,   rdata_d;
    logic [1:0]      rresp_q,   rresp_d;
    logic [31:0]     r_addr_q,  r_addr_d;
    logic [3:0]      r_len_q,   r_len_d;
    logic [2:0]      r_size_q,  r_size_d;
    logic [1:0]      r_burst_q, r_burst_d;
    logic [3:0]      r_beat_q,  r_beat_d;

    logic [31:0]     rg_addr;
    logic [3:0]      rg_len;
    logic [2:0]      rg_size;
    logic [1:0]      rg_burst;
    logic [31:0]     r_next_addr;
    logic            r_legal;
    logic            r_fetch;
    logic [31:0]     r_fetch_addr;

    // Beat 0 is fetched in the accept cycle, so legality must be judged on
    // the live AR fields while idle and on the latched burst afterwards.
    assign rg_addr  = (r_state_q == R_IDLE) ? axi.araddr  : r_addr_q;
    assign rg_len   = (r_state_q == R_IDLE) ? axi.arlen   : r_len_q;
    assign rg_size  = (r_state_q == R_IDLE) ? axi.arsize  : r_size_q;
    assign rg_burst = (r_state_q == R_IDLE) ? axi.arburst : r_burst_q;

    axi_addr_gen u_rd_gen (
        .addr      (rg_addr),
        .len       (rg_len),
        .size      (rg_size),
        .burst     (rg_burst),
        .next_addr (r_next_addr),
        .legal     (r_legal)
    );

    always_comb begin
        r_state_d    = r_state_q;
        arready_d    = arready_q;
        rvalid_d     = rvalid_q;
        rlast_d      = rlast_q;
        rid_d        = rid_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_size_d     = r_size_q;
        r_burst_d    = r_burst_q;
        r_beat_d     = r_beat_q;
        r_fetch      = 1'b0;
        r_fetch_addr = r_next_addr;

        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi.arvalid && arready_q) begin
                    rid_d        = axi.arid;
                    r_addr_d     = axi.araddr;
                    r_len_d      = axi.arlen;
                    r_size_d     = axi.arsize;
                    r_burst_d    = axi.arburst;
                    r_beat_d     = 4'd0;
                    rlast_d      = (axi.arlen == 4'd0);
                    rvalid_d     = 1'b1;
                    arready_d    = 1'b0;
                    r_fetch      = 1'b1;
                    r_fetch_addr = axi.araddr;
                    r_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.rready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d     = r_next_addr;
                        r_beat_d     = r_beat_q + 4'd1;
                        rlast_d      = ((r_beat_q + 4'd1) == r_len_q);
                        r_fetch      = 1'b1;
                        r_fetch_addr = r_next_addr;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // Fetch reads the array before any same-edge write lands.
        if (r_fetch) begin
            if (r_legal && in_range(r_fetch_addr)) begin
                rdata_d = mem[widx(r_fetch_addr)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = 32'd0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rlast   = rlast_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
`timescale 1ns/1ps
module tb_axi_slave_mem;
    import axi_pkg::*;

    localparam int MEM_DEPTH = 1024;
    localparam int ID_W      = 4;

    logic aclk = 1'b0;
    logic arst = 1'b0;
    always #5 aclk = ~aclk;

    axi_inf #(.ID_W(ID_W)) axi ();

    axi_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .ID_W(ID_W)) dut (
        .aclk (aclk),
        .arst (arst),
        .axi  (axi)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference memory: word array updated from the protocol rules
    logic [31:0] ref_mem [MEM_DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input int size, input logic [1:0] burst, input int i);
        longint s, bytes, span, base;
        s     = longint'({32'd0, start});
        bytes = longint'(1) << size;
        span  = longint'(len + 1) * bytes;
        if (burst == 2'b00) return start;
        if (burst == 2'b10) begin
            base = (s / span) * span;
            return 32'(base + ((s - base) + longint'(i) * bytes) % span);
        end
        return 32'(s + longint'(i) * bytes);
    endfunction

    function automatic bit burst_ok(input int len, input int size, input logic [1:0] burst);
        if (burst == 2'b11 || size > 2) return 1'b0;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit word_ok(input logic [31:0] a);
        return (a >> 2) < MEM_DEPTH;
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input int size, input logic [1:0] burst, input logic [3:0] wid,
                             input bit bad_wlast, input int bdelay, input string tag);
        logic [31:0] a;
        logic [1:0]  exp_resp;
        bit          err;
        int          n;
        exp_resp      = RESP_OKAY;
        axi.awid      = id;
        axi.awaddr    = addr;
        axi.awlen     = 4'(len);
        axi.awsize    = 3'(size);
        axi.awburst   = burst;
        axi.awvalid   = 1'b1;
        n = 0;
        while (axi.awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk({tag, "_awready"}, 32'(axi.awready), 32'd1);
        @(negedge aclk);
        axi.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            axi.wid    = wid;
            axi.wdata  = wd[i];
            axi.wstrb  = ws[i];
            axi.wlast  = (i == len) ^ bad_wlast;
            axi.wvalid = 1'b1;
            chk({tag, "_wready"}, 32'(axi.wready), 32'd1);
            n = 0;
            while (axi.wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
            a   = beat_addr(addr, len, size, burst, i);
            err = !burst_ok(len, size, burst) || !word_ok(a) || (wid != id) || bad_wlast;
            if (err) exp_resp = RESP_SLVERR;
            else begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[int'(a >> 2)][8*b +: 8] = wd[i][8*b +: 8];
            end
            @(negedge aclk);
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        chk({tag, "_bvalid"}, 32'(axi.bvalid), 32'd1);
        chk({tag, "_bid"},    32'(axi.bid),    32'(id));
        chk({tag, "_bresp"},  32'(axi.bresp),  32'(exp_resp));
        for (int k = 0; k < bdelay; k++) begin
            @(negedge aclk);
            chk({tag, "_bvalid_hold"}, 32'(axi.bvalid), 32'd1);
            chk({tag, "_bresp_hold"},  32'(axi.bresp),  32'(exp_resp));
        end
        axi.bready = 1'b1;
        n = 0;
        while (axi.bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        @(negedge aclk);
        axi.bready = 1'b0;
        chk({tag, "_bvalid_drop"}, 32'(axi.bvalid),  32'd0);
        chk({tag, "_awready_back"}, 32'(axi.awready), 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input logic [1:0] burst, input int stall_beat,
                            input int stall_cycles, input string tag, output logic [31:0] last_data);
        logic [31:0] a, exp_d;
        logic [1:0]  exp_r;
        bit          err;
        int          n;
        last_data   = 32'd0;
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = 4'(len);
        axi.arsize  = 3'(size);
        axi.arburst = burst;
        axi.arvalid = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk({tag, "_arready"}, 32'(axi.arready), 32'd1);
        @(negedge aclk);
        axi.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a     = beat_addr(addr, len, size, burst, i);
            err   = !burst_ok(len, size, burst) || !word_ok(a);
            exp_d = err ? 32'd0 : ref_mem[int'(a >> 2)];
            exp_r = err ? RESP_SLVERR : RESP_OKAY;
            chk({tag, "_rvalid"}, 32'(axi.rvalid), 32'd1);
            chk({tag, "_rdata"},  axi.rdata,       exp_d);
            chk({tag, "_rresp"},  32'(axi.rresp),  32'(exp_r));
            chk({tag, "_rlast"},  32'(axi.rlast),  32'(i == len));
            chk({tag, "_rid"},    32'(axi.rid),    32'(id));
            last_data = axi.rdata;
            if (i == stall_beat) begin
                axi.rready = 1'b0;
                for (int k = 0; k < stall_cycles; k++) begin
                    @(negedge aclk);
                    chk({tag, "_stall_rvalid"}, 32'(axi.rvalid), 32'd1);
                    chk({tag, "_stall_rdata"},  axi.rdata,       exp_d);
                    chk({tag, "_stall_rlast"},  32'(axi.rlast),  32'(i == len));
                end
            end
            axi.rready = 1'b1;
            @(negedge aclk);
        end
        axi.rready = 1'b0;
        chk({tag, "_rvalid_end"},  32'(axi.rvalid),  32'd0);
        chk({tag, "_arready_end"}, 32'(axi.arready), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dout;
        int          bt, ln, sw, n;
        logic [1:0]  bu;
        logic [3:0]  id;

        {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst} = '0;
        {axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion, axi.awvalid} = '0;
        {axi.wid, axi.wdata, axi.wstrb, axi.wlast, axi.wvalid, axi.bready} = '0;
        {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst} = '0;
        {axi.arlock, axi.arcache, axi.arprot, axi.arqos, axi.arregion, axi.arvalid} = '0;
        axi.rready = 1'b0;

        // reset values
        repeat (3) @(negedge aclk);
        chk("rst_awready", 32'(axi.awready), 32'd0);
        chk("rst_wready",  32'(axi.wready),  32'd0);
        chk("rst_bvalid",  32'(axi.bvalid),  32'd0);
        chk("rst_bid",     32'(axi.bid),     32'd0);
        chk("rst_bresp",   32'(axi.bresp),   32'd0);
        chk("rst_arready", 32'(axi.arready), 32'd0);
        chk("rst_rvalid",  32'(axi.rvalid),  32'd0);
        chk("rst_rlast",   32'(axi.rlast),   32'd0);
        chk("rst_rid",     32'(axi.rid),     32'd0);
        chk("rst_rdata",   axi.rdata,        32'd0);
        chk("rst_rresp",   32'(axi.rresp),   32'd0);
        arst = 1'b1;
        @(negedge aclk);
        chk("post_rst_awready", 32'(axi.awready), 32'd1);
        chk("post_rst_arready", 32'(axi.arready), 32'd1);

        // known contents for words 0..63
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom(); ws[i] = 4'hF; end
            axi_write(4'(blk), 32'(blk * 64), 15, 2, BURST_INCR, 4'(blk), 1'b0, 0, "fill");
        end

        // INCR write/read with an R stall on beat 1
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'h1, 32'h10, 3, 2, BURST_INCR, 4'h1, 1'b0, 0, "incr_w");
        axi_read(4'h2, 32'h10, 3, 2, BURST_INCR, 1, 3, "incr_r", dout);
        chk("incr_r_last_word", dout, 32'hA3);

        // WRAP write/read
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'h3, 32'h18, 3, 2, BURST_WRAP, 4'h3, 1'b0, 0, "wrap_w");
        axi_read(4'h3, 32'h18, 3, 2, BURST_WRAP, 99, 0, "wrap_r", dout);
        chk("wrap_r_4th_at_0x14", dout, 32'hB3);

        // byte strobes
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        axi_write(4'h4, 32'h40, 0, 2, BURST_INCR, 4'h4, 1'b0, 0, "strb_full");
        wd[0] = 32'h1234_5678; ws[0] = 4'h3;
        axi_write(4'h4, 32'h40, 0, 2, BURST_INCR, 4'h4, 1'b0, 0, "strb_half");
        axi_read(4'h4, 32'h40, 0, 2, BURST_INCR, 99, 0, "strb_r", dout);
        chk("strb_merge", dout, 32'hFFFF_5678);

        // out-of-range and range-crossing reads
        axi_read(4'h5, 32'(4 * MEM_DEPTH), 1, 2, BURST_INCR, 99, 0, "oob_r", dout);
        axi_read(4'h6, 32'(4 * MEM_DEPTH - 4), 1, 2, BURST_INCR, 0, 1, "edge_r", dout);

        // error writes: wid mismatch (slow bready), reserved burst, bad WRAP len, bad wlast
        for (int i = 0; i < 16; i++) begin wd[i] = 32'hDEAD_0000 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'h3, 32'h20, 1, 2, BURST_INCR, 4'h5, 1'b0, 5, "widmis_w");
        axi_read(4'h3, 32'h20, 1, 2, BURST_INCR, 99, 0, "widmis_r", dout);
        axi_write(4'h7, 32'h30, 1, 2, BURST_RSVD, 4'h7, 1'b0, 0, "rsvd_w");
        axi_read(4'h7, 32'h30, 1, 2, BURST_RSVD, 99, 0, "rsvd_r", dout);
        axi_write(4'h8, 32'h30, 2, 2, BURST_WRAP, 4'h8, 1'b0, 0, "wraplen_w");
        axi_write(4'h9, 32'h30, 1, 3, BURST_INCR, 4'h9, 1'b0, 0, "size_w");
        axi_write(4'hA, 32'h30, 1, 2, BURST_INCR, 4'hA, 1'b1, 1, "wlast_w");
        axi_read(4'hA, 32'h30, 1, 2, BURST_INCR, 99, 0, "err_chk_r", dout);

        // randomized bursts within words 0..63
        for (int it = 0; it < 10; it++) begin
            bt = $urandom_range(0, 2);
            id = 4'($urandom());
            case (bt)
                0:       begin bu = BURST_FIXED; ln = $urandom_range(0, 3); end
                1:       begin bu = BURST_INCR;  ln = $urandom_range(0, 15); end
                default: begin bu = BURST_WRAP;  ln = (2 << $urandom_range(0, 3)) - 1; end
            endcase
            sw = (bu == BURST_INCR) ? $urandom_range(0, 63 - ln) : $urandom_range(0, 63);
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom(); ws[i] = 4'($urandom_range(0, 15)); end
            axi_write(id, 32'(sw * 4), ln, 2, bu, id, 1'b0, $urandom_range(0, 2), "rnd_w");
            axi_read(id, 32'(sw * 4), ln, 2, bu, $urandom_range(0, ln), $urandom_range(0, 2), "rnd_r", dout);
        end

        // reset in the middle of a read burst
        axi.arid = 4'hC; axi.araddr = 32'h0; axi.arlen = 4'd7;
        axi.arsize = 3'd2; axi.arburst = BURST_INCR; axi.arvalid = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        chk("mid_arready", 32'(axi.arready), 32'd1);
        @(negedge aclk);
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        chk("mid_rvalid_before", 32'(axi.rvalid), 32'd1);
        arst = 1'b0;
        #1;
        chk("mid_rvalid_rst",  32'(axi.rvalid),  32'd0);
        chk("mid_rlast_rst",   32'(axi.rlast),   32'd0);
        chk("mid_arready_rst", 32'(axi.arready), 32'd0);
        chk("mid_rdata_rst",   axi.rdata,        32'd0);
        axi.rready = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        arst = 1'b1;
        @(negedge aclk);
        chk("mid_arready_after", 32'(axi.arready), 32'd1);
        chk("mid_rvalid_after",  32'(axi.rvalid),  32'd0);

        // contents survive reset
        axi_read(4'hD, 32'h0, 15, 2, BURST_INCR, 99, 0, "post_rst_r", dout);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
